// File: rtl/axi_ar_burst_splitter.sv
// Splits one AXI AR burst into per-beat memory read requests (FIXED/INCR, optional WRAP).
// Optional feature: define AXI_AR_WRAP_SUPPORT_EN to build WRAP address generation.
module axi_ar_burst_splitter #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic [2:0]           ar_size_i,
  input  logic [1:0]           ar_burst_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [AddrWidth-1:0] req_addr_o,
  output logic [IdWidth-1:0]   req_id_o,
  output logic                 req_last_o
);
  localparam int unsigned MaxSize = $clog2(DataWidth / 8);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state;
  logic [IdWidth-1:0]   id_q;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           len_q;
  logic [7:0]           cnt;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;

  logic                 busy, req_hs, ar_hs;
  logic [2:0]           eff_size;
  logic [AddrWidth-1:0] step, incr_addr, next_addr;

  assign busy        = (state == BUSY);
  assign req_valid_o = busy;
  assign req_addr_o  = addr_q;
  assign req_id_o    = id_q;
  assign req_last_o  = busy && (cnt == len_q);

  assign req_hs = req_valid_o && req_ready_i;
  // A new burst may enter on the same cycle the previous last beat leaves.
  assign ar_ready_o = !flush_i && (!busy || (req_hs && req_last_o));
  assign ar_hs      = ar_valid_i && ar_ready_o;

  assign eff_size  = (size_q > 3'(MaxSize)) ? 3'(MaxSize) : size_q;
  assign step      = AddrWidth'(1) << eff_size;
  assign incr_addr = (addr_q & ~(step - AddrWidth'(1))) + step;

`ifdef AXI_AR_WRAP_SUPPORT_EN
  logic [AddrWidth-1:0] wrap_mask;
  assign wrap_mask = ((AddrWidth'(len_q) + AddrWidth'(1)) << eff_size) - AddrWidth'(1);
`endif

  always_comb begin
    next_addr = incr_addr;
    if (burst_q == 2'd0) next_addr = addr_q;
`ifdef AXI_AR_WRAP_SUPPORT_EN
    else if (burst_q == 2'd2) next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt     <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (ar_hs) begin
      state   <= BUSY;
      id_q    <= ar_id_i;
      addr_q  <= ar_addr_i;
      len_q   <= ar_len_i;
      size_q  <= ar_size_i;
      burst_q <= ar_burst_i;
      cnt     <= '0;
    end else if (req_hs) begin
      if (req_last_o) begin
        state <= IDLE;
      end else begin
        cnt    <= cnt + 8'd1;
        addr_q <= next_addr;
      end
    end
  end
endmodule

// File: tb/tb_axi_ar_burst_splitter.sv
// Directed + randomized bench for axi_ar_burst_splitter against an arithmetic beat-address model.
module tb_axi_ar_burst_splitter;
  localparam int AW = 64, IW = 4, DW = 64;
  localparam int MAXS = 3;

  logic          clk_i = 0, rst_ni = 0, flush_i = 0, ar_valid_i = 0, req_ready_i = 0;
  logic [IW-1:0] ar_id_i = '0;
  logic [AW-1:0] ar_addr_i = '0;
  logic [7:0]    ar_len_i = '0;
  logic [2:0]    ar_size_i = '0;
  logic [1:0]    ar_burst_i = '0;
  logic          ar_ready_o, req_valid_o, req_last_o;
  logic [AW-1:0] req_addr_o;
  logic [IW-1:0] req_id_o;

  int errors = 0, checks = 0;

  axi_ar_burst_splitter #(.AddrWidth(AW), .IdWidth(IW), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .req_id_o(req_id_o), .req_last_o(req_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address of beat i, from the AXI rules written as plain arithmetic.
  function automatic logic [63:0] beat_addr(input logic [63:0] start, input int len,
                                            input int size, input int burst, input int i);
    int          es;
    logic [63:0] step, aligned, wl, base;
    es      = (size > MAXS) ? MAXS : size;
    step    = 64'd1 << es;
    aligned = start - (start % step);
    if (i == 0 || burst == 0) return start;
`ifdef AXI_AR_WRAP_SUPPORT_EN
    if (burst == 2) begin
      wl   = 64'(len + 1) * step;
      base = aligned - (aligned % wl);
      return base + ((aligned - base + 64'(i) * step) % wl);
    end
`endif
    wl   = 0;
    base = 0;
    return aligned + 64'(i) * step;
  endfunction

  task automatic set_ar(input logic [IW-1:0] id, input logic [63:0] addr, input int len,
                        input int size, input int burst);
    ar_id_i = id; ar_addr_i = addr; ar_len_i = 8'(len); ar_size_i = 3'(size); ar_burst_i = 2'(burst);
  endtask

  // mode: 0 always ready, 1 toggle ready, 2 random ready
  task automatic do_burst(input logic [IW-1:0] id, input logic [63:0] addr, input int len,
                          input int size, input int burst, input int mode);
    int k = 0, cyc = 0;
    @(negedge clk_i);
    ar_valid_i = 1; req_ready_i = 0;
    set_ar(id, addr, len, size, burst);
    #1;
    while (!ar_ready_o && cyc < 20) begin @(negedge clk_i); #1; cyc++; end
    chk("ar_ready_idle", 64'(ar_ready_o), 64'd1);
    @(negedge clk_i);
    ar_valid_i = 0;
    cyc = 0;
    while (k <= len && cyc < 3000) begin
      req_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      #1;
      chk("req_valid", 64'(req_valid_o), 64'd1);
      chk("req_addr", req_addr_o, beat_addr(addr, len, size, burst, k));
      chk("req_id", 64'(req_id_o), 64'(id));
      chk("req_last", 64'(req_last_o), 64'(k == len));
      if (req_ready_i) k++;
      cyc++;
      @(negedge clk_i);
    end
    if (k <= len) chk("burst_timeout", 64'(k), 64'(len + 1));
    req_ready_i = 0;
    #1;
    chk("end_valid", 64'(req_valid_o), 64'd0);
    chk("end_ar_ready", 64'(ar_ready_o), 64'd1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ar_ready", 64'(ar_ready_o), 64'd1);
    chk("rst_req_valid", 64'(req_valid_o), 64'd0);
    chk("rst_req_addr", req_addr_o, 64'd0);
    chk("rst_req_id", 64'(req_id_o), 64'd0);
    chk("rst_req_last", 64'(req_last_o), 64'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1;

    // INCR unaligned start, WRAP, FIXED with toggled ready
    do_burst(4'h3, 64'h1003, 3, 3, 1, 0);
    do_burst(4'h4, 64'h38, 3, 3, 2, 0);
    do_burst(4'h5, 64'h200, 2, 3, 0, 1);

    // Back-to-back: B accepted on A's last-beat cycle
    @(negedge clk_i);
    ar_valid_i = 1; req_ready_i = 1;
    set_ar(4'h1, 64'h100, 0, 3, 1);
    #1 chk("b2b_a_ready", 64'(ar_ready_o), 64'd1);
    @(negedge clk_i);
    set_ar(4'h2, 64'h300, 1, 3, 1);
    #1;
    chk("b2b_a_valid", 64'(req_valid_o), 64'd1);
    chk("b2b_a_id", 64'(req_id_o), 64'd1);
    chk("b2b_a_last", 64'(req_last_o), 64'd1);
    chk("b2b_b_ready", 64'(ar_ready_o), 64'd1);
    @(negedge clk_i);
    ar_valid_i = 0;
    #1;
    chk("b2b_b0_valid", 64'(req_valid_o), 64'd1);
    chk("b2b_b0_id", 64'(req_id_o), 64'd2);
    chk("b2b_b0_addr", req_addr_o, 64'h300);
    chk("b2b_b0_last", 64'(req_last_o), 64'd0);
    @(negedge clk_i); #1;
    chk("b2b_b1_valid", 64'(req_valid_o), 64'd1);
    chk("b2b_b1_addr", req_addr_o, 64'h308);
    chk("b2b_b1_last", 64'(req_last_o), 64'd1);
    @(negedge clk_i); #1;
    chk("b2b_done", 64'(req_valid_o), 64'd0);

    // Flush on beat 2 of a len=7 INCR burst with a new AR pending
    @(negedge clk_i);
    req_ready_i = 1; ar_valid_i = 1;
    set_ar(4'h7, 64'h0, 7, 3, 1);
    @(negedge clk_i);
    ar_valid_i = 0;
    #1 chk("fl_beat1", req_addr_o, 64'h0);
    @(negedge clk_i);
    flush_i = 1; ar_valid_i = 1;
    set_ar(4'h9, 64'h500, 1, 3, 1);
    #1;
    chk("fl_beat2", req_addr_o, 64'h8);
    chk("fl_ar_ready", 64'(ar_ready_o), 64'd0);
    @(negedge clk_i);
    flush_i = 0;
    #1;
    chk("fl_valid_drop", 64'(req_valid_o), 64'd0);
    chk("fl_ar_ready_back", 64'(ar_ready_o), 64'd1);
    @(negedge clk_i);
    ar_valid_i = 0;
    #1;
    chk("fl_c0_id", 64'(req_id_o), 64'h9);
    chk("fl_c0_addr", req_addr_o, 64'h500);
    chk("fl_c0_last", 64'(req_last_o), 64'd0);
    @(negedge clk_i); #1;
    chk("fl_c1_addr", req_addr_o, 64'h508);
    chk("fl_c1_last", 64'(req_last_o), 64'd1);
    @(negedge clk_i); #1;
    chk("fl_done", 64'(req_valid_o), 64'd0);

    // Size clamp
    do_burst(4'h6, 64'h40, 2, 7, 1, 0);

    // Reset mid-burst
    @(negedge clk_i);
    ar_valid_i = 1; req_ready_i = 1;
    set_ar(4'hA, 64'h900, 5, 3, 1);
    @(negedge clk_i);
    ar_valid_i = 0;
    @(negedge clk_i);
    rst_ni = 0;
    #1;
    chk("rstm_valid", 64'(req_valid_o), 64'd0);
    chk("rstm_ar_ready", 64'(ar_ready_o), 64'd1);
    chk("rstm_last", 64'(req_last_o), 64'd0);
    chk("rstm_addr", req_addr_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1;

    // Randomized bursts
    for (int n = 0; n < 40; n++) begin
      int          b, sz, ln, es;
      logic [63:0] a;
      b  = int'($urandom_range(0, 3));
      sz = int'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      if (b == 2) begin
        ln = (2 << $urandom_range(0, 3)) - 1;
        es = (sz > MAXS) ? MAXS : sz;
        a  = a & ~((64'd1 << es) - 64'd1);
      end else begin
        ln = int'($urandom_range(0, 20));
      end
      do_burst(4'($urandom), a, ln, sz, b, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
